// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if
//   Handshake bundle for imm_gen_pipe.
//   Input side : in_valid, in_ready, in_instr[31:0], in_imm_sel[2:0], in_tag[TAG_W-1:0]
//   Output side: out_valid, out_ready, out_imm[XLEN-1:0], out_type[2:0], out_illegal,
//                out_tag[TAG_W-1:0]
//   master: the surrounding pipeline (drives in_*, out_ready)
//   slave : the immediate generator (drives in_ready, out_*)
`timescale 1ns/1ps
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_imm_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_type;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_imm_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_imm_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Registered, handshaked immediate generator for the decode stage. Decodes the
//   immediate format of a 32-bit instruction (from the opcode, or from in_imm_sel
//   when AUTO_SEL=0), sign-extends it to XLEN and holds results in a 2-entry skid
//   buffer so in_ready never depends combinationally on out_ready.
// Ports
//   clk, rst_n (async, active-low), flush (synchronous kill of all held entries)
//   bus (imm_gen_pipe_if.slave):
//     in_valid/in_ready/in_instr/in_imm_sel/in_tag  upstream handshake
//     out_valid/out_ready/out_imm/out_type/out_illegal/out_tag  downstream handshake
// Parameters
//   XLEN (32|64), TAG_W, AUTO_SEL (1: opcode decode, 0: in_imm_sel)
// Configuration macro
//   IMMGEN_ZICSR_EN: enables the Z format (zero-extended instr[19:15]) for
//   SYSTEM opcodes with instr[14]=1 and for manual select 5.
`timescale 1ns/1ps
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TAG_W    = 32,
    parameter bit          AUTO_SEL = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4,
        FMT_Z = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       typ;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_e state;
    entry_t main_q;
    entry_t skid_q;
    entry_t dec_entry;
    logic   out_valid_q;
    logic   in_ready_q;

    fmt_e            fmt;
    logic            ill;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
    logic [XLEN-1:0] dec_imm;

    assign instr = bus.in_instr;

    // Format resolution
    always_comb begin
        fmt = FMT_I;
        ill = 1'b0;
        if (AUTO_SEL) begin
            case (instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
                7'b0100011:                         fmt = FMT_S;
                7'b1100011:                         fmt = FMT_B;
                7'b0110111, 7'b0010111:             fmt = FMT_U;
                7'b1101111:                         fmt = FMT_J;
                7'b1110011: begin
`ifdef IMMGEN_ZICSR_EN
                    // funct3[2] selects the immediate (uimm) CSR forms
                    if (instr[14]) fmt = FMT_Z;
                    else           fmt = FMT_I;
`else
                    fmt = FMT_I;
`endif
                end
                default: ill = 1'b1;
            endcase
        end else begin
            case (bus.in_imm_sel)
                3'd0: fmt = FMT_I;
                3'd1: fmt = FMT_S;
                3'd2: fmt = FMT_B;
                3'd3: fmt = FMT_U;
                3'd4: fmt = FMT_J;
`ifdef IMMGEN_ZICSR_EN
                3'd5: fmt = FMT_Z;
`endif
                default: ill = 1'b1;
            endcase
        end
    end

    // Every format's sign bit is instr[31]: pre-fill with it, then overwrite the
    // low field. This works for both XLEN values without zero-width replications.
    always_comb begin
        imm_i        = {XLEN{instr[31]}};
        imm_i[11:0]  = instr[31:20];
        imm_s        = {XLEN{instr[31]}};
        imm_s[11:0]  = {instr[31:25], instr[11:7]};
        imm_b        = {XLEN{instr[31]}};
        imm_b[12:0]  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u        = {XLEN{instr[31]}};
        imm_u[31:0]  = {instr[31:12], 12'b0};
        imm_j        = {XLEN{instr[31]}};
        imm_j[20:0]  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_z        = '0;
        imm_z[4:0]   = instr[19:15];

        dec_imm = '0;
        if (!ill) begin
            case (fmt)
                FMT_I:   dec_imm = imm_i;
                FMT_S:   dec_imm = imm_s;
                FMT_B:   dec_imm = imm_b;
                FMT_U:   dec_imm = imm_u;
                FMT_J:   dec_imm = imm_j;
                FMT_Z:   dec_imm = imm_z;
                default: dec_imm = '0;
            endcase
        end
    end

    always_comb begin
        dec_entry.imm = dec_imm;
        dec_entry.typ = fmt;
        dec_entry.ill = ill;
        dec_entry.tag = bus.in_tag;
    end

    logic in_fire, out_fire;
    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    // Skid buffer: outputs come only from main_q; skid_q holds the second entry
    // accepted while the downstream stalls and refills main when it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state       <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_q      <= dec_entry;
                        out_valid_q <= 1'b1;
                        state       <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_q     <= dec_entry;
                        in_ready_q <= 1'b0;
                        state      <= S_FULL;
                    end else if (in_fire) begin
                        main_q <= dec_entry;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state       <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= S_ONE;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_type    = main_q.typ;
    assign bus.out_illegal = main_q.ill;
    assign bus.out_tag     = main_q.tag;

endmodule
